// File: rtl/fetch_decode_queue.sv
// DEPTH-entry {pc, instr} queue between fetch and decode; 1-cycle fill latency, no empty bypass.
// Back-pressure: in_ready drops only when full (no pass-through on full); flush drops everything at the next edge.
module fetch_decode_queue #(
  parameter int          DEPTH       = 2,
  parameter int          PC_WIDTH    = 64,
  parameter int          INSTR_WIDTH = 32,
  parameter logic [63:0] RESET_PC    = 64'h8000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  localparam logic [PtrW-1:0]     PtrOne    = PtrW'(1);
  localparam logic [CntW-1:0]     CntOne    = CntW'(1);
  localparam logic [CntW-1:0]     FullCount = CntW'(DEPTH);
  localparam logic [PC_WIDTH-1:0] ResetPc   = PC_WIDTH'(RESET_PC);

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic            push;
  logic            pop;

  // Handshake readiness depends on occupancy only; flush is applied at the edge.
  assign in_ready  = (count < FullCount);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign out_pc    = out_valid ? mem[rdPtr].pc    : ResetPc;
  assign out_instr = out_valid ? mem[rdPtr].instr : '0;

  // Storage is deliberately left unreset; out_valid gates what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= '{pc: in_pc, instr: in_instr};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PtrOne;
      end
      if (pop) begin
        rdPtr <= rdPtr + PtrOne;
      end
      if (push && !pop) begin
        count <= count + CntOne;
      end else if (pop && !push) begin
        count <= count - CntOne;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DEPTH=2): vector table plus streaming and async-reset sequences.
module tb_fetch_decode_queue;

  localparam logic [63:0] ResetPc = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic [63:0] inPc;
  logic [31:0] inInstr;
  logic        inReady;
  logic        outValid;
  logic [63:0] outPc;
  logic [31:0] outInstr;
  logic        outReady;
  logic        flush;
  logic [1:0]  count;

  int checks = 0;
  int failures = 0;

  fetch_decode_queue #(
    .DEPTH(2), .PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'h8000_0000)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(inValid), .in_pc(inPc), .in_instr(inInstr), .in_ready(inReady),
    .out_valid(outValid), .out_pc(outPc), .out_instr(outInstr), .out_ready(outReady),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        inValid;
    logic [63:0] inPc;
    logic [31:0] inInstr;
    logic        outReady;
    logic        flush;
    logic        expVld;
    logic [63:0] expPc;
    logic [31:0] expInstr;
    logic        expRdy;
    logic [1:0]  expCnt;
  } vec_t;

  localparam int NumVecs = 12;
  vec_t vecs [NumVecs];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic vld, input logic [63:0] pc,
                          input logic [31:0] instr, input logic rdy, input logic [1:0] cnt);
    checkVal({tag, ".out_valid"}, 64'(outValid), 64'(vld));
    checkVal({tag, ".out_pc"},    outPc,         pc);
    checkVal({tag, ".out_instr"}, 64'(outInstr), 64'(instr));
    checkVal({tag, ".in_ready"},  64'(inReady),  64'(rdy));
    checkVal({tag, ".count"},     64'(count),    64'(cnt));
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                       input logic ordy, input logic fl);
    inValid  = v;
    inPc     = pc;
    inInstr  = instr;
    outReady = ordy;
    flush    = fl;
  endtask

  initial begin
    // inV, inPc, inInstr, outRdy, flush | expVld, expPc, expInstr, expRdy, expCnt
    vecs[0]  = '{1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b1, 2'd1};
    vecs[1]  = '{1'b0, 64'h0,         32'h0,         1'b1, 1'b0, 1'b0, ResetPc,       32'h0,         1'b1, 2'd0};
    vecs[2]  = '{1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b1, 2'd1};
    vecs[3]  = '{1'b1, 64'h8000_0004, 32'h0040_0093, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 2'd2};
    vecs[4]  = '{1'b1, 64'h8000_0008, 32'h0080_0113, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 2'd2};
    vecs[5]  = '{1'b1, 64'h8000_0008, 32'h0080_0113, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 2'd2};
    vecs[6]  = '{1'b1, 64'h8000_0008, 32'h0080_0113, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 2'd2};
    // Full: pop only, the held entry is not taken on the same edge.
    vecs[7]  = '{1'b1, 64'h8000_0008, 32'h0080_0113, 1'b1, 1'b0, 1'b1, 64'h8000_0004, 32'h0040_0093, 1'b1, 2'd1};
    vecs[8]  = '{1'b1, 64'h8000_0008, 32'h0080_0113, 1'b0, 1'b0, 1'b1, 64'h8000_0004, 32'h0040_0093, 1'b0, 2'd2};
    vecs[9]  = '{1'b1, 64'h8000_0100, 32'h0000_0013, 1'b1, 1'b1, 1'b0, ResetPc,       32'h0,         1'b1, 2'd0};
    // Flush beats a push into an empty queue; pop on empty is ignored.
    vecs[10] = '{1'b1, 64'h8000_0200, 32'h1234_5678, 1'b0, 1'b1, 1'b0, ResetPc,       32'h0,         1'b1, 2'd0};
    vecs[11] = '{1'b0, 64'h0,         32'h0,         1'b1, 1'b0, 1'b0, ResetPc,       32'h0,         1'b1, 2'd0};

    reset = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkAll("reset", 1'b0, ResetPc, 32'h0, 1'b1, 2'd0);

    for (int i = 0; i < NumVecs; i++) begin
      @(negedge clk);
      drive(vecs[i].inValid, vecs[i].inPc, vecs[i].inInstr, vecs[i].outReady, vecs[i].flush);
      @(posedge clk);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].expVld, vecs[i].expPc, vecs[i].expInstr,
               vecs[i].expRdy, vecs[i].expCnt);
    end

    // Streaming: after the first edge every edge pops entry i-1 and pushes entry i.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i), 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkAll($sformatf("stream%0d", i), 1'b1, 64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i),
               1'b1, 2'd1);
    end

    // Asynchronous reset between edges, with one entry still queued.
    @(negedge clk);
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkAll("async_reset", 1'b0, ResetPc, 32'h0, 1'b1, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkAll("post_reset_push", 1'b1, 64'h8000_0000, 32'h0000_0013, 1'b1, 2'd1);
    @(negedge clk);
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkAll("post_reset_pop", 1'b0, ResetPc, 32'h0, 1'b1, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
